// File: rtl/conv_tap_feeder_if.sv
// ============================================================================
// Module  : conv_tap_feeder_if
// Purpose : Weight-load, pixel-stream and product-word bundle for the tap feeder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_tap_feeder_if #(
  parameter int PIX_W = 8
);
  logic               w_load;
  logic [3*PIX_W-1:0] w_data;
  logic               in_valid;
  logic               in_ready;
  logic [PIX_W-1:0]   in_pix;
  logic [47:0]        pix_out;
  logic               conv_en;
  logic               win_valid;
  logic               row_done;

  // Source side: supplies weights and pixels, consumes product words.
  modport master (
    output w_load, w_data, in_valid, in_pix,
    input  in_ready, pix_out, conv_en, win_valid, row_done
  );

  // Feeder side.
  modport slave (
    input  w_load, w_data, in_valid, in_pix,
    output in_ready, pix_out, conv_en, win_valid, row_done
  );
endinterface

`default_nettype wire

// File: rtl/conv_tap_feeder.sv
// ============================================================================
// Module  : conv_tap_feeder
// Purpose : Multiplies each pixel by three row weights and feeds the product
//           triple to a 3-tap accumulator, flushing it at every row end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_tap_feeder #(
  parameter int PIX_W   = 8,
  parameter int ROW_LEN = 28
) (
  input  logic               clk,
  input  logic               rst,
  conv_tap_feeder_if.slave   bus
);

  localparam int                c_COL_W = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 2;
  localparam logic [c_COL_W-1:0] c_LAST  = c_COL_W'(ROW_LEN - 1);
  localparam logic [c_COL_W-1:0] c_WIN0  = c_COL_W'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_COL_W-1:0]   r_col_cnt;
  logic [c_COL_W-1:0]   w_col_nxt;
  logic                 r_flush_cnt;
  logic                 w_flush_nxt;
  logic                 r_done_pend;
  logic                 w_done_pend_nxt;
  logic                 w_wt_load;
  logic                 w_accept;
  logic                 w_col_zero;
  logic [PIX_W-1:0]     r_wt [3];
  logic [47:0]          w_prod;
  logic [47:0]          r_pix_out;
  logic                 r_conv_en;
  logic                 r_win_valid;
  logic                 r_row_done;

  assign w_col_zero   = (r_col_cnt == '0);
  // A weight load at column 0 wins over a pixel offered in the same cycle.
  assign bus.in_ready = rst && (r_state == S_RUN) && !(bus.w_load && w_col_zero);
  assign w_accept     = bus.in_valid && bus.in_ready;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_tap
      assign w_prod[k*16 +: 16] = 16'(bus.in_pix) * 16'(r_wt[k]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_col_cnt   <= '0;
      r_flush_cnt <= 1'b0;
      r_done_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col_cnt   <= w_col_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_done_pend <= w_done_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col_cnt;
    w_flush_nxt     = r_flush_cnt;
    w_done_pend_nxt = 1'b0;
    w_wt_load       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.w_load) begin
          w_wt_load   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.w_load && w_col_zero) begin
          w_wt_load = 1'b1;
        end else if (w_accept) begin
          if (r_col_cnt == c_LAST) begin
            w_col_nxt   = '0;
            w_flush_nxt = 1'b0;
            w_state_nxt = S_FLUSH;
          end else begin
            w_col_nxt = r_col_cnt + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        w_flush_nxt = 1'b1;
        if (r_flush_cnt) begin
          // row_done trails the second zero word by one cycle
          w_flush_nxt     = 1'b0;
          w_done_pend_nxt = 1'b1;
          w_state_nxt     = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wt[0]     <= '0;
      r_wt[1]     <= '0;
      r_wt[2]     <= '0;
      r_pix_out   <= '0;
      r_conv_en   <= 1'b0;
      r_win_valid <= 1'b0;
      r_row_done  <= 1'b0;
    end else begin
      if (w_wt_load) begin
        r_wt[0] <= bus.w_data[0*PIX_W +: PIX_W];
        r_wt[1] <= bus.w_data[1*PIX_W +: PIX_W];
        r_wt[2] <= bus.w_data[2*PIX_W +: PIX_W];
      end
      if (w_accept) begin
        r_pix_out   <= w_prod;
        r_conv_en   <= 1'b1;
        r_win_valid <= (r_col_cnt >= c_WIN0);
      end else if (r_state == S_FLUSH) begin
        r_pix_out   <= '0;
        r_conv_en   <= 1'b1;
        r_win_valid <= 1'b0;
      end else begin
        r_conv_en   <= 1'b0;
        r_win_valid <= 1'b0;
      end
      r_row_done <= r_done_pend;
    end
  end

  assign bus.pix_out   = r_pix_out;
  assign bus.conv_en   = r_conv_en;
  assign bus.win_valid = r_win_valid;
  assign bus.row_done  = r_row_done;

endmodule

`default_nettype wire

// File: doc/conv_tap_feeder.md
CONV_TAP_FEEDER -- requirements
Module: conv_tap_feeder

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning input pixel and per-weight width.
REQ-002 SHALL have parameter ROW_LEN, default 28, meaning pixels per row (legal range 3..1023).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port w_load  input  1  weight-load strobe.
REQ-006 SHALL have port w_data  input  3*PIX_W  weights; [7:0]=w0, [15:8]=w1, [23:16]=w2 (default widths).
REQ-007 SHALL have port in_valid  input  1  pixel valid.
REQ-008 SHALL have port in_ready  output  1  pixel accepted when in_valid&&in_ready.
REQ-009 SHALL have port in_pix  input  PIX_W  unsigned pixel.
REQ-010 SHALL have port pix_out  output  48  product triple to the 3-tap accumulator; [15:0]=x*w0, [31:16]=x*w1, [47:32]=x*w2.
REQ-011 SHALL have port conv_en  output  1  accumulator advance strobe, one per pix_out word.
REQ-012 SHALL have port win_valid  output  1  high with conv_en when accumulator output after this advance is a full 3-pixel window.
REQ-013 SHALL have port row_done  output  1  one-cycle pulse after a row is fully drained.

Function
REQ-014 SHALL implement states IDLE, RUN, FLUSH.
REQ-015 SHALL leave IDLE for RUN only on a cycle with w_load=1, capturing w_data.
REQ-016 SHALL accept w_load in RUN only when col_cnt==0; w_load is ignored at other RUN columns and in FLUSH.
REQ-017 SHALL drive in_ready = (state==RUN) && !(w_load && col_cnt==0); a weight load takes priority over a pixel in the same cycle.
REQ-018 SHALL, on pixel acceptance, form three unsigned PIX_W x PIX_W products, zero-extended to 16 bits each, and register them into pix_out, with conv_en=1 at the next edge (latency 1 cycle).
REQ-019 SHALL hold pix_out and drive conv_en=0 on any RUN cycle without acceptance; stalls of any length are legal.
REQ-020 SHALL keep col_cnt 0..ROW_LEN-1, incremented per accepted pixel; win_valid=1 with conv_en iff the accepted pixel's column >=2.
REQ-021 SHALL, on accepting column ROW_LEN-1, reset col_cnt to 0 and enter FLUSH.
REQ-022 SHALL in FLUSH emit exactly 2 cycles of pix_out=0, conv_en=1, win_valid=0, with in_ready=0.
REQ-023 SHALL pulse row_done for 1 cycle on the cycle after the second flush word, return to RUN and retain weights.
REQ-024 SHALL never drive win_valid=1 while conv_en=0.

Reset
REQ-025 SHALL, when rst=0 at a rising edge, set state=IDLE, col_cnt=0, weights=0, pix_out=0, conv_en=0, win_valid=0, row_done=0.
REQ-026 SHALL drive in_ready=0 while rst=0 and in IDLE.
REQ-027 SHALL, on reset mid-row or mid-FLUSH, abandon the row with no flush and no row_done; weights must be reloaded.

Verification (ROW_LEN=4, w_data={8'd3,8'd2,8'd1})
REQ-028 SHALL check: load, then pixel 10 accepted -> next cycle pix_out=48'h001E_0014_000A, conv_en=1, win_valid=0.
REQ-029 SHALL check: pixels 1,2,3,4 back-to-back -> conv_en on 4 consecutive cycles, win_valid 0,0,1,1, then 2 zero words with conv_en=1, then row_done pulse; with the downstream accumulator, outputs 14 and 20.
REQ-030 SHALL check: in_valid low 3 cycles between pixels 2 and 3 -> conv_en=0 and pix_out held during the gap, same final sums.
REQ-031 SHALL check: w_load={8'd1,8'd1,8'd1} together with in_valid at col 0 -> in_ready=0, weights updated, pixel 200 next cycle -> pix_out=48'h00C8_00C8_00C8; w_load at col 2 is ignored.
REQ-032 SHALL check: rst=0 during FLUSH -> next cycle all outputs 0, state IDLE, no row_done, in_ready=0 until a new w_load.
REQ-033 SHALL check: max operands 255 x 255 -> each slice 16'hFE01, no truncation.
